// File: rtl/icache.sv
// rtl/icache.sv - direct-mapped one-word-per-line instruction cache; optional ICACHE_FILL_FORWARD_EN
module icache #(
    parameter int INDEX_WIDTH = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        rdy,
    input  logic        rollback,
    input  logic        fetch_req,
    input  logic [31:0] fetch_pc,
    output logic        hit,
    output logic [31:0] ins,
    output logic [31:0] pc_out,
    output logic        pc_miss_sgn,
    input  logic        finish_ins,
    input  logic [31:0] ins_in
);

    localparam int LINES     = 1 << INDEX_WIDTH;
    localparam int TAG_WIDTH = 30 - INDEX_WIDTH;

    typedef enum logic {
        IDLE,
        MISS
    } state_t;

    state_t state_q, state_d;

    logic [LINES-1:0]     valid_q;
    logic [TAG_WIDTH-1:0] tag_q  [LINES];
    logic [31:0]          data_q [LINES];

    logic [INDEX_WIDTH-1:0] fetch_idx;
    logic [INDEX_WIDTH-1:0] fill_idx;
    logic [TAG_WIDTH-1:0]   fetch_tag;
    logic [TAG_WIDTH-1:0]   fill_tag;
    logic                   lookup_hit;
    logic                   start_miss;
    logic                   fill_we;
    logic                   unused_pc_bits;

    assign fetch_idx  = fetch_pc[INDEX_WIDTH+1:2];
    assign fetch_tag  = fetch_pc[31:INDEX_WIDTH+2];
    assign fill_idx   = pc_out[INDEX_WIDTH+1:2];
    assign fill_tag   = pc_out[31:INDEX_WIDTH+2];
    assign lookup_hit = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);

    // Byte-offset bits of the fetch address carry no information for word fetches.
    assign unused_pc_bits = ^fetch_pc[1:0];

    // Next-state and output decode; rollback or rdy low suppresses hit and fill.
    always_comb begin
        state_d     = state_q;
        hit         = 1'b0;
        ins         = data_q[fetch_idx];
        pc_miss_sgn = 1'b0;
        start_miss  = 1'b0;
        fill_we     = 1'b0;
        case (state_q)
            IDLE: begin
                hit = rdy && fetch_req && !rollback && lookup_hit;
                if (rdy && fetch_req && !rollback && !lookup_hit) begin
                    start_miss = 1'b1;
                    state_d    = MISS;
                end
            end
            MISS: begin
                // Low in the completion cycle so memory_control does not re-issue.
                pc_miss_sgn = !finish_ins && !rollback;
                if (rdy && finish_ins && !rollback) begin
                    fill_we = 1'b1;
                    state_d = IDLE;
                end
`ifdef ICACHE_FILL_FORWARD_EN
                if (rdy && finish_ins && !rollback && fetch_req &&
                    (fetch_pc[31:2] == pc_out[31:2])) begin
                    hit = 1'b1;
                    ins = ins_in;
                end
`else
`endif
            end
        endcase
        if (rdy && rollback) begin
            state_d = IDLE;
        end
    end

    // State, valid bits and latched miss address; everything holds while rdy is low.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
            pc_out  <= '0;
        end else if (rdy) begin
            state_q <= state_d;
            if (start_miss) begin
                pc_out <= {fetch_pc[31:2], 2'b00};
            end
            if (fill_we) begin
                valid_q[fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays need no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (rst_n && fill_we) begin
            tag_q[fill_idx]  <= fill_tag;
            data_q[fill_idx] <= ins_in;
        end
    end

endmodule

// File: tb/tb_icache.sv
// tb/tb_icache.sv - scoreboard bench for icache with a latency-modelled memory_control
module tb_icache;

    localparam int LAT = 6;
`ifdef ICACHE_FILL_FORWARD_EN
    localparam int MISS_LAT = LAT + 1;
`else
    localparam int MISS_LAT = LAT + 2;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        rdy;
    logic        rollback;
    logic        fetch_req;
    logic [31:0] fetch_pc;
    logic        hit;
    logic [31:0] ins;
    logic [31:0] pc_out;
    logic        pc_miss_sgn;
    logic        finish_ins;
    logic [31:0] ins_in;

    int checks = 0;
    int errors = 0;
    int miss_cnt = 0;
    logic [31:0] exp_q[$];

    icache #(.INDEX_WIDTH(6)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rdy         (rdy),
        .rollback    (rollback),
        .fetch_req   (fetch_req),
        .fetch_pc    (fetch_pc),
        .hit         (hit),
        .ins         (ins),
        .pc_out      (pc_out),
        .pc_miss_sgn (pc_miss_sgn),
        .finish_ins  (finish_ins),
        .ins_in      (ins_in)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] pc);
        if (pc == 32'h4) return 32'h00A00093;
        return (pc * 32'h9E3779B1) ^ 32'h00000013;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // memory_control model: answers a held request after LAT enabled cycles
    initial begin
        int  cnt;
        bit  req;
        bit  rdy_s;
        bit  rst_s;
        cnt        = 0;
        finish_ins = 1'b0;
        ins_in     = '0;
        forever begin
            @(negedge clk);
            req   = pc_miss_sgn;
            rdy_s = rdy;
            rst_s = rst_n;
            step();
            finish_ins = 1'b0;
            ins_in     = $urandom;
            if (!rst_s) begin
                cnt = 0;
            end else if (rdy_s) begin
                if (req) begin
                    cnt++;
                    if (cnt >= LAT) begin
                        finish_ins = 1'b1;
                        ins_in     = mem_word(pc_out);
                        cnt        = 0;
                    end
                end else begin
                    cnt = 0;
                end
            end
        end
    end

    // Monitor: counts request assertions, pops scoreboard on every delivered hit
    initial begin
        bit prev;
        prev = 1'b0;
        forever begin
            @(negedge clk);
            if (pc_miss_sgn && !prev) miss_cnt++;
            prev = pc_miss_sgn;
            if (finish_ins) check("fin_cycle_sgn", pc_miss_sgn, 0);
            if (hit && fetch_req) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_hit", hit, 0);
                end else begin
                    check("hit_ins", ins, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_fetch(input logic [31:0] pc, input int exp_lat);
        int cyc;
        int m0;
        m0        = miss_cnt;
        fetch_pc  = pc;
        fetch_req = 1'b1;
        exp_q.push_back(mem_word(pc));
        cyc = 0;
        forever begin
            @(negedge clk);
            if (hit) break;
            cyc++;
            if (cyc > 200) break;
            step();
        end
        check("fetch_latency", cyc, exp_lat);
        step();
        fetch_req = 1'b0;
        check("miss_requests", miss_cnt - m0, (exp_lat == 0) ? 0 : 1);
    endtask

    typedef struct {
        logic [31:0] pc;
        bit          hit;
    } fetch_t;

    fetch_t tbl[8] = '{
        '{32'h20, 1'b0}, '{32'h24, 1'b0}, '{32'h20, 1'b1}, '{32'h24, 1'b1},
        '{32'h28, 1'b0}, '{32'h2020, 1'b0}, '{32'h20, 1'b0}, '{32'h28, 1'b1}
    };

    initial begin
        #2000000;
        $display("FAIL global_timeout got=%0d exp=%0d", 1, 0);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n     = 1'b0;
        rdy       = 1'b1;
        rollback  = 1'b0;
        fetch_req = 1'b1;
        fetch_pc  = 32'h4;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hit", hit, 0);
        check("rst_sgn", pc_miss_sgn, 0);
        check("rst_pc_out", pc_out, 0);
        step();
        fetch_req = 1'b0;
        rst_n     = 1'b1;
        step();

        // cold fetch of 0x4
        fork
            do_fetch(32'h4, MISS_LAT);
            begin
                @(negedge clk);
                check("cold_c0_sgn", pc_miss_sgn, 0);
                @(negedge clk);
                check("cold_c1_sgn", pc_miss_sgn, 1);
                check("cold_c1_pc_out", pc_out, 32'h4);
            end
        join
        do_fetch(32'h4, 0);

        // index conflict
        do_fetch(32'h104, MISS_LAT);
        do_fetch(32'h4, MISS_LAT);

        // rollback two cycles into MISS
        fetch_pc  = 32'h8;
        fetch_req = 1'b1;
        repeat (3) step();
        rollback = 1'b1;
        @(negedge clk);
        check("rb_sgn", pc_miss_sgn, 0);
        check("rb_hit", hit, 0);
        step();
        rollback  = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        check("rb_idle_sgn", pc_miss_sgn, 0);
        repeat (2) step();
        do_fetch(32'h8, MISS_LAT);

        // rollback coinciding with finish_ins discards the fill
        fetch_pc  = 32'hC;
        fetch_req = 1'b1;
        repeat (LAT + 1) step();
        rollback = 1'b1;
        @(negedge clk);
        check("rbf_finish_seen", finish_ins, 1);
        check("rbf_hit", hit, 0);
        check("rbf_sgn", pc_miss_sgn, 0);
        step();
        rollback  = 1'b0;
        fetch_req = 1'b0;
        @(negedge clk);
        check("rbf_idle_sgn", pc_miss_sgn, 0);
        step();
        do_fetch(32'hC, MISS_LAT);

        // rdy low for three cycles mid-miss
        fork
            do_fetch(32'h10, MISS_LAT + 3);
            begin
                repeat (2) step();
                rdy = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    check("rdy_low_hit", hit, 0);
                    check("rdy_low_sgn", pc_miss_sgn, 1);
                    check("rdy_low_pc_out", pc_out, 32'h10);
                end
                step();
                rdy = 1'b1;
            end
        join

        // mixed table
        foreach (tbl[i]) do_fetch(tbl[i].pc, tbl[i].hit ? 0 : MISS_LAT);

        // reset with lines valid
        do_fetch(32'h4, 0);
        rst_n = 1'b0;
        repeat (2) step();
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_pc_out", pc_out, 0);
        check("post_rst_sgn", pc_miss_sgn, 0);
        step();
        do_fetch(32'h4, MISS_LAT);
        do_fetch(32'h8, MISS_LAT);
        do_fetch(32'hC, MISS_LAT);
        do_fetch(32'h10, MISS_LAT);

        repeat (2) step();
        check("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-line instruction cache between the fetch unit and `memory_control`. Fetch lookups that hit return the instruction in the same cycle. A miss latches the PC, drives the memory controller's instruction-fetch request until `finish_ins` returns the word, and then writes the line. Valid bits are cleared only by reset, so rollback cancels an outstanding fill but leaves cached lines intact.

## Interface
- `INDEX_WIDTH`, default 6: index bits, giving 2^INDEX_WIDTH lines of 32 bits. Index = pc[INDEX_WIDTH+1:2]; tag = pc[31:INDEX_WIDTH+2].
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, synchronous and active-low.
- `rdy`  in  1  global enable; when low, all state freezes.
- `rollback`  in  1  flush request from the ROB.
- `fetch_req`  in  1  fetch unit requests the instruction at `fetch_pc`.
- `fetch_pc`  in  32  fetch address; bits [1:0] are ignored.
- `hit`  out  1  combinational; `ins` is valid for `fetch_pc` this cycle.
- `ins`  out  32  combinational instruction word.
- `pc_out`  out  32  registered miss address to `memory_control` (`pc_in`).
- `pc_miss_sgn`  out  1  combinational fetch request to `memory_control`.
- `finish_ins`  in  1  one-cycle completion pulse from `memory_control`.
- `ins_in`  in  32  fill word from `memory_control` (`ins_out`); valid while `finish_ins` is high.

## Operation
- Storage per line: valid bit, tag, 32-bit data. Reset (`rst_n`=0 at a clock edge) clears all valid bits, sets the state to IDLE and sets `pc_out` to 0.
- State IDLE:
  - `hit` = `rdy` & `fetch_req` & valid[idx] & (tag[idx]==fetch tag).
  - `ins` = data[idx].
  - On `fetch_req` & !hit & `rdy` & !`rollback`: `pc_out` <= {fetch_pc[31:2],2'b00}, and the state goes to MISS.
- State MISS:
  - `pc_miss_sgn` = (state==MISS) & !`finish_ins` & !`rollback`.
  - `pc_miss_sgn` must be combinational. `memory_control` samples it again in the cycle after `finish_ins` and would otherwise start a duplicate fetch.
  - `hit` = 0, except for the forward case in Configuration.
  - On `finish_ins` & `rdy`: write valid=1, tag and data=`ins_in` to the line selected by `pc_out`, then go to IDLE.
- Rollback, in any state, at the edge: state <= IDLE and no fill is written. A `finish_ins` arriving in the same cycle is discarded. `hit` is forced to 0 in a rollback cycle.
- `rdy`=0: no state, array or `pc_out` update; `hit`=0. `pc_miss_sgn` keeps its combinational value, which is harmless because `memory_control` is also frozen.
- The fetch unit holds `fetch_pc` and `fetch_req` until `hit`. If `fetch_pc` changes during MISS, the fill still completes to the latched address, and the new PC is then looked up in IDLE.
- Reset while in MISS: state returns to IDLE, all lines become invalid, and no fill occurs.

## Timing
- Hit latency: 0 cycles; `hit` and `ins` are asserted in the same cycle as `fetch_req`.
- Miss, without the forward option:
  - cycle 0: lookup misses.
  - cycle 1: MISS entered, `pc_miss_sgn`=1.
  - `memory_control` returns `finish_ins` after about 6 cycles.
  - fill cycle F: line written, state goes to IDLE.
  - cycle F+1: lookup hits.
- Every `pc_miss_sgn` assertion is held continuously until the `finish_ins` cycle or a rollback cycle, and it is low in both of those cycles.
- All outputs after reset: `hit`=0 (no valid lines), `ins`=data[idx] (don't-care), `pc_out`=0, `pc_miss_sgn`=0.

## Configuration
- Macro `ICACHE_FILL_FORWARD_EN`.
- When defined:
  - In the fill cycle, if `fetch_req` & (fetch_pc[31:2]==pc_out[31:2]), then `hit`=1 and `ins`=`ins_in`.
  - This saves one cycle per miss. The array write still occurs.
- When undefined: `hit` is 0 throughout MISS, including the fill cycle, and the result is returned by the IDLE lookup on the next cycle.

## Test plan
- Cold fetch of pc=0x0000_0004 with memory returning 0x00A00093:
  - `pc_miss_sgn` rises one cycle after the request, with `pc_out`=0x4.
  - `pc_miss_sgn` is low in the `finish_ins` cycle.
  - Without the forward option, `hit`=1 with `ins`=0x00A00093 one cycle later.
- Re-fetch of pc=0x4 after the fill: `hit`=1 in the same cycle, and `pc_miss_sgn` never asserts.
- Conflict with INDEX_WIDTH=6: fill 0x0004, then fetch 0x0104 (same index, different tag).
  - The second fetch misses and refills.
  - A later fetch of 0x0004 misses again.
- Rollback two cycles into a MISS:
  - `pc_miss_sgn` goes to 0 in the rollback cycle, and the state is IDLE at the next edge.
  - The line stays invalid; a later fetch of the same PC misses again.
- `rdy` low for 3 cycles mid-miss: no state change and `hit` held at 0. The fill completes normally after `rdy` returns.
- Reset with 4 lines valid: all four PCs miss after `rst_n` rises. With `ICACHE_FILL_FORWARD_EN` defined, a cold miss asserts `hit` in the `finish_ins` cycle with `ins`=`ins_in`.
